pc_fetch_ctrl: RTL and testbench

- Program-counter register and instruction-fetch sequencer.
- Sits directly downstream of the next-PC select multiplexer: it consumes the selected next PC, holds the architectural PC, and drives instruction memory through a req/ready handshake.
- Presents the fetched instruction to decode with a valid/stall handshake.
- Also produces pc_plus4, which feeds the sequential input of the next-PC multiplexer.

---
 rtl/pc_fetch_pkg.sv | 29 ++
 rtl/pc_reg.sv | 53 +++++
 rtl/pc_fetch_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_pkg
// Description : Shared types and constants for the PC / instruction-fetch
//               sequencer. Optional feature macro: PC_MISALIGN_TRAP_EN
//               (adds the TRAP state).
// Revision    : 1.0 - initial release
// ============================================================================
package pc_fetch_pkg;

    // Fetch sequencer states; TRAP exists only when misalignment trapping is built in
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
`ifdef PC_MISALIGN_TRAP_EN
        ,
        TRAP  = 2'd3
`endif
    } fetch_state_t;

    // Sequential PC increment in bytes
    localparam int unsigned PC_INCR = 4;

    // Default PC loaded on reset
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : pc_reg
// Description : Program-counter register with load enable, synchronous reset
//               and pc+4 adder. Owns the word-alignment policy: without
//               PC_MISALIGN_TRAP_EN the low two bits are masked on load; with
//               it the value is stored as-is and flagged when misaligned.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_reg
    import pc_fetch_pkg::*;
#(
    parameter int unsigned  N        = 32,
    parameter logic [N-1:0] RESET_PC = N'(RESET_PC_DEFAULT)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_en_i,
    input  logic [N-1:0] load_val_i,
    output logic [N-1:0] pc_o,
    output logic [N-1:0] pc_plus4_o
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic         misaligned_o
`endif
);

    logic [N-1:0] pc_q;
    logic [N-1:0] w_load_val;

`ifdef PC_MISALIGN_TRAP_EN
    // Offending value is kept so the trap handler can see it
    assign w_load_val   = load_val_i;
    assign misaligned_o = |load_val_i[1:0];
`else
    // Force word alignment on every load
    assign w_load_val   = load_val_i & ~N'(3);
`endif

    // PC register: reset to RESET_PC, otherwise update only on load
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (load_en_i) begin
            pc_q <= w_load_val;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_q + N'(PC_INCR);   // wraps modulo 2^N

endmodule
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_ctrl
// Description : Architectural PC holder and instruction-fetch sequencer.
//               Issues req/ready fetches to instruction memory, presents the
//               fetched word to decode with valid/stall, and handles flush
//               redirects (including redirects that arrive while a request is
//               still outstanding). Optional feature macro:
//               PC_MISALIGN_TRAP_EN (misaligned-PC trap, fetch_misaligned).
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl
    import pc_fetch_pkg::*;
#(
    parameter int unsigned  N        = 32,
    parameter logic [N-1:0] RESET_PC = N'(RESET_PC_DEFAULT),
    parameter int unsigned  IW       = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  next_pc,
    output logic [N-1:0]  pc_out,
    output logic [N-1:0]  pc_plus4,
    output logic          imem_req,
    output logic [N-1:0]  imem_addr,
    input  logic          imem_ready,
    input  logic [IW-1:0] imem_rdata,
    output logic [IW-1:0] instr_out,
    output logic          instr_valid,
    input  logic          stall_in,
    input  logic          flush,
    input  logic [N-1:0]  flush_pc
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic          fetch_misaligned
`endif
);

    fetch_state_t  state_q, state_d;
    logic          pend_q, pend_d;      // flush arrived while request outstanding
    logic [N-1:0]  tgt_q, tgt_d;        // latched redirect target
    logic [IW-1:0] instr_q, instr_d;
    logic          valid_q, valid_d;

    logic          w_pc_load;
    logic [N-1:0]  w_load_val;
    fetch_state_t  w_load_state;        // where the FSM goes after a PC load

`ifdef PC_MISALIGN_TRAP_EN
    logic          mis_q, mis_d;
    logic          w_pc_misaligned;
`endif

    // Load-value select: a live flush wins, then a pending redirect, then next_pc.
    // pend_q can only be set while in FETCH, so in IDLE/HOLD this yields next_pc.
    assign w_load_val = flush  ? flush_pc :
                        pend_q ? tgt_q    : next_pc;

    pc_reg #(
        .N        (N),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk          (clk),
        .rst          (rst),
        .load_en_i    (w_pc_load),
        .load_val_i   (w_load_val),
        .pc_o         (pc_out),
        .pc_plus4_o   (pc_plus4)
`ifdef PC_MISALIGN_TRAP_EN
        ,
        .misaligned_o (w_pc_misaligned)
`endif
    );

`ifdef PC_MISALIGN_TRAP_EN
    assign w_load_state = w_pc_misaligned ? TRAP : FETCH;
`else
    assign w_load_state = FETCH;
`endif

    // State, redirect latch and instruction register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            tgt_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            tgt_q   <= tgt_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
`ifdef PC_MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`endif
        end
    end

    // Next-state logic, PC load control and memory request
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        tgt_d     = tgt_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        w_pc_load = 1'b0;
        imem_req  = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (flush) begin
                    w_pc_load = 1'b1;
                    valid_d   = 1'b0;
                    state_d   = w_load_state;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    if (flush || pend_q) begin
                        // Response belongs to a redirected-away PC: drop it
                        w_pc_load = 1'b1;
                        pend_d    = 1'b0;
                        state_d   = w_load_state;
                    end else begin
                        instr_d = imem_rdata;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end else if (flush) begin
                    // Keep the outstanding request stable; redirect once it completes
                    tgt_d  = flush_pc;
                    pend_d = 1'b1;
                end
            end
            HOLD: begin
                if (flush || !stall_in) begin
                    w_pc_load = 1'b1;
                    valid_d   = 1'b0;
                    state_d   = w_load_state;
                end
            end
`ifdef PC_MISALIGN_TRAP_EN
            TRAP: begin
                valid_d = 1'b0;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef PC_MISALIGN_TRAP_EN
        mis_d = mis_q | (w_pc_load & w_pc_misaligned);
`endif
    end

    assign imem_addr   = pc_out;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
`ifdef PC_MISALIGN_TRAP_EN
    assign fetch_misaligned = mis_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_ctrl
// Description : Directed self-checking bench for pc_fetch_ctrl. Memory model
//               returns addr ^ 32'hC0DE0000. Optional feature macro:
//               PC_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_ctrl;

    localparam int unsigned N  = 32;
    localparam int unsigned IW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  next_pc;
    logic [N-1:0]  pc_out;
    logic [N-1:0]  pc_plus4;
    logic          imem_req;
    logic [N-1:0]  imem_addr;
    logic          imem_ready;
    logic [IW-1:0] imem_rdata;
    logic [IW-1:0] instr_out;
    logic          instr_valid;
    logic          stall_in;
    logic          flush;
    logic [N-1:0]  flush_pc;
`ifdef PC_MISALIGN_TRAP_EN
    logic          fetch_misaligned;
`endif

    logic          seq_mode;
    logic [N-1:0]  np_ovr;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    // Stimulus plumbing: next_pc either follows pc+4 or a directed value
    assign next_pc    = seq_mode ? pc_plus4 : np_ovr;
    assign imem_rdata = imem_addr ^ 32'hC0DE0000;

    pc_fetch_ctrl #(
        .N        (N),
        .RESET_PC (32'h0),
        .IW       (IW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .next_pc          (next_pc),
        .pc_out           (pc_out),
        .pc_plus4         (pc_plus4),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ready       (imem_ready),
        .imem_rdata       (imem_rdata),
        .instr_out        (instr_out),
        .instr_valid      (instr_valid),
        .stall_in         (stall_in),
        .flush            (flush),
        .flush_pc         (flush_pc)
`ifdef PC_MISALIGN_TRAP_EN
        ,
        .fetch_misaligned (fetch_misaligned)
`endif
    );

    function automatic logic [31:0] exp_instr(input logic [31:0] addr);
        return addr ^ 32'hC0DE0000;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; imem_ready = 1'b1; stall_in = 1'b0; flush = 1'b0;
        flush_pc = '0; seq_mode = 1'b1; np_ovr = '0;
        tick(); tick();

        // Reset state
        check_eq("rst_pc",    pc_out, 32'h0);
        check_eq("rst_valid", instr_valid, 1'b0);
        check_eq("rst_req",   imem_req, 1'b0);
        check_eq("rst_instr", instr_out, 32'h0);

        // Sequential fetch, zero wait states: first request one cycle after reset
        rst = 1'b0;
        check_eq("idle_req", imem_req, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check_eq("seq_req",   imem_req, 1'b1);
            check_eq("seq_addr",  imem_addr, 32'(4 * i));
            check_eq("seq_vld0",  instr_valid, 1'b0);
            tick();
            check_eq("seq_vld1",  instr_valid, 1'b1);
            check_eq("seq_instr", instr_out, exp_instr(32'(4 * i)));
            check_eq("seq_hreq",  imem_req, 1'b0);
            tick();
        end

        // Wait states at 0x10: ready after 3 cycles, address stable for 4
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) imem_ready = 1'b1;
            check_eq("ws_addr", imem_addr, 32'h10);
            check_eq("ws_req",  imem_req, 1'b1);
            check_eq("ws_vld",  instr_valid, 1'b0);
            tick();
        end
        // Stall for 2 HOLD cycles: valid high 3 cycles, PC unchanged until release
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) stall_in = 1'b0;
            check_eq("st_vld",   instr_valid, 1'b1);
            check_eq("st_pc",    pc_out, 32'h10);
            check_eq("st_instr", instr_out, exp_instr(32'h10));
            tick();
        end
        check_eq("st_after_pc",  pc_out, 32'h14);
        check_eq("st_after_vld", instr_valid, 1'b0);

        // Flush during an outstanding request at 0x20
        tick();                                 // HOLD at 0x14
        seq_mode = 1'b0; np_ovr = 32'h20;
        tick();                                 // FETCH at 0x20
        check_eq("fl_addr0", imem_addr, 32'h20);
        imem_ready = 1'b0; flush = 1'b1; flush_pc = 32'h100;
        tick();
        flush = 1'b0;
        check_eq("fl_stable", imem_addr, 32'h20);
        check_eq("fl_req",    imem_req, 1'b1);
        tick();
        check_eq("fl_stable2", imem_addr, 32'h20);
        check_eq("fl_vld0",    instr_valid, 1'b0);
        imem_ready = 1'b1;
        tick();
        check_eq("fl_drop_vld", instr_valid, 1'b0);
        check_eq("fl_new_addr", imem_addr, 32'h100);
        check_eq("fl_new_req",  imem_req, 1'b1);
        tick();
        check_eq("fl_hold_vld",   instr_valid, 1'b1);
        check_eq("fl_hold_instr", instr_out, exp_instr(32'h100));

        // Flush in HOLD beats stall
        stall_in = 1'b1; flush = 1'b1; flush_pc = 32'h40;
        tick();
        flush = 1'b0; stall_in = 1'b0;
        check_eq("fh_vld",  instr_valid, 1'b0);
        check_eq("fh_addr", imem_addr, 32'h40);
        check_eq("fh_req",  imem_req, 1'b1);

        // Reset mid-request with a pending redirect: both must be discarded
        imem_ready = 1'b0;
        tick();
        flush = 1'b1; flush_pc = 32'h300;
        tick();
        flush = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rm_pc",    pc_out, 32'h0);
        check_eq("rm_vld",   instr_valid, 1'b0);
        check_eq("rm_req",   imem_req, 1'b0);
        imem_ready = 1'b1;
        tick();
        check_eq("rm_addr",  imem_addr, 32'h0);
        check_eq("rm_freq",  imem_req, 1'b1);
        tick();
        check_eq("rm_vld1",  instr_valid, 1'b1);
        check_eq("rm_instr", instr_out, exp_instr(32'h0));

        // Wrap-around
        np_ovr = 32'hFFFF_FFFC;
        tick();
        check_eq("wr_pc",  pc_out, 32'hFFFF_FFFC);
        check_eq("wr_p4",  pc_plus4, 32'h0);
        tick();
        check_eq("wr_instr", instr_out, exp_instr(32'hFFFF_FFFC));

        // Misaligned next_pc
        np_ovr = 32'h202;
        tick();
`ifdef PC_MISALIGN_TRAP_EN
        check_eq("mis_flag", fetch_misaligned, 1'b1);
        check_eq("mis_req",  imem_req, 1'b0);
        check_eq("mis_pc",   pc_out, 32'h202);
        check_eq("mis_vld",  instr_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("mis_noreq", imem_req, 1'b0);
            check_eq("mis_stick", fetch_misaligned, 1'b1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mis_clr", fetch_misaligned, 1'b0);
        check_eq("mis_rpc", pc_out, 32'h0);
`else
        check_eq("al_addr", imem_addr, 32'h200);
        check_eq("al_req",  imem_req, 1'b1);
        tick();
        check_eq("al_instr", instr_out, exp_instr(32'h200));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
